alu_rr_scheduler: RTL and testbench

//  Shares one 256-bit SIMD ALU (32 x 8-bit lanes; modes ADD/AND/OR/XOR) among NUM_REQ requesters.

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_rr_scheduler_rr_arbiter.sv | 32 +++
 rtl/alu_rr_scheduler.sv | 121 ++++++++++++
 tb/tb_alu_rr_scheduler.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the SIMD ALU scheduler slice.
package alu_pkg;

  localparam int unsigned ALU_LANE_W = 8;

  typedef logic [1:0] alu_mode_t;

  localparam alu_mode_t ALU_ADD = 2'b00;
  localparam alu_mode_t ALU_AND = 2'b01;
  localparam alu_mode_t ALU_OR  = 2'b10;
  localparam alu_mode_t ALU_XOR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } sched_state_t;

endpackage

// File: rtl/alu_rr_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted req at or after ptr, wrapping mod N.
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [IW:0] idx;
  logic        found;

  // Scan N slots starting at ptr; the extra idx bit absorbs the wrap before the modulo fold.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = {1'b0, ptr} + (IW+1)'(k);
      if (idx >= (IW+1)'(N)) idx = idx - (IW+1)'(N);
      if (!found && req[idx[IW-1:0]]) begin
        found              = 1'b1;
        gnt[idx[IW-1:0]]   = 1'b1;
        gnt_idx            = idx[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler sharing one external SIMD ALU among NUM_REQ requesters.
module alu_rr_scheduler
  import alu_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DW      = 256,
  parameter int unsigned IDW     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*DW-1:0] req_op0,
  input  logic [NUM_REQ*DW-1:0] req_op1,
  input  logic [NUM_REQ*2-1:0]  req_mode,
  output logic [DW-1:0]         alu_op0,
  output logic [DW-1:0]         alu_op1,
  output logic [1:0]            alu_mode,
  input  logic [DW-1:0]         alu_out,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DW-1:0]         rsp_data,
  output logic [IDW-1:0]        rsp_id,
  output logic                  busy
);

  sched_state_t state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [DW-1:0]  alu_op0_q, alu_op0_d, alu_op1_q, alu_op1_d;
  alu_mode_t      alu_mode_q, alu_mode_d;
  logic [DW-1:0]  rsp_data_q, rsp_data_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [NUM_REQ-1:0] gnt;
  logic [IDW-1:0] gnt_idx;
  logic           accept;
  int unsigned    sel;

  rr_arbiter #(.N(NUM_REQ), .IW(IDW)) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)    state_d = EXEC;
      EXEC:                   state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Grant is only offered from IDLE and is suppressed while reset is held.
  always_comb begin
    req_ready = '0;
    busy      = 1'b0;
    if (state_q == IDLE && !rst) req_ready = gnt;
    if (state_q != IDLE)         busy      = 1'b1;
  end

  assign accept = (state_q == IDLE) && |(req_valid & req_ready);

  always_comb begin
    sel         = 32'(gnt_idx);
    rr_ptr_d    = rr_ptr_q;
    alu_op0_d   = alu_op0_q;
    alu_op1_d   = alu_op1_q;
    alu_mode_d  = alu_mode_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = rsp_valid_q;
    if (accept) begin
      alu_op0_d  = req_op0[sel*DW +: DW];
      alu_op1_d  = req_op1[sel*DW +: DW];
      alu_mode_d = alu_mode_t'(req_mode[sel*2 +: 2]);
      rsp_id_d   = gnt_idx;
      rr_ptr_d   = (gnt_idx == IDW'(NUM_REQ-1)) ? '0 : gnt_idx + IDW'(1);
    end
    if (state_q == EXEC) begin
      rsp_data_d  = alu_out;
      rsp_valid_d = 1'b1;
    end
    if (state_q == RESP && rsp_ready) rsp_valid_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      alu_op0_q   <= '0;
      alu_op1_q   <= '0;
      alu_mode_q  <= ALU_ADD;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      alu_op0_q   <= alu_op0_d;
      alu_op1_q   <= alu_op1_d;
      alu_mode_q  <= alu_mode_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign alu_op0   = alu_op0_q;
  assign alu_op1   = alu_op1_q;
  assign alu_mode  = alu_mode_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_valid = rsp_valid_q;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Bench for alu_rr_scheduler: lane-level ALU stand-in plus a round-robin reference model.
module tb_alu_rr_scheduler;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned DW      = 256;
  localparam int unsigned IDW     = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*DW-1:0] req_op0, req_op1;
  logic [NUM_REQ*2-1:0]  req_mode;
  logic [DW-1:0]         alu_op0, alu_op1, alu_out;
  logic [1:0]            alu_mode;
  logic                  rsp_valid, rsp_ready, busy;
  logic [DW-1:0]         rsp_data;
  logic [IDW-1:0]        rsp_id;

  int checks = 0;
  int errors = 0;
  int mptr   = 0;

  alu_rr_scheduler #(.NUM_REQ(NUM_REQ), .DW(DW), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1), .req_mode(req_mode),
    .alu_op0(alu_op0), .alu_op1(alu_op1), .alu_mode(alu_mode), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] alu_fn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [1:0] m);
    logic [DW-1:0] r;
    r = '0;
    for (int l = 0; l < int'(DW / 8); l++) begin
      case (m)
        2'b00:   r[l*8 +: 8] = a[l*8 +: 8] + b[l*8 +: 8];
        2'b01:   r[l*8 +: 8] = a[l*8 +: 8] & b[l*8 +: 8];
        2'b10:   r[l*8 +: 8] = a[l*8 +: 8] | b[l*8 +: 8];
        default: r[l*8 +: 8] = a[l*8 +: 8] ^ b[l*8 +: 8];
      endcase
    end
    return r;
  endfunction

  always_comb alu_out = alu_fn(alu_op0, alu_op1, alu_mode);

  function automatic int ref_winner(input logic [NUM_REQ-1:0] v, input int p);
    for (int k = 0; k < int'(NUM_REQ); k++)
      if (v[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
    return -1;
  endfunction

  function automatic logic [NUM_REQ*DW-1:0] rand_vec();
    logic [NUM_REQ*DW-1:0] v;
    for (int w = 0; w < int'(NUM_REQ*DW/32); w++) v[w*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    mptr = 0;
  endtask

  // One full transaction: wait for a grant, then follow EXEC, RESP (stalled 'hold' cycles) and back to IDLE.
  task automatic serve(input int hold, output int id, output logic [DW-1:0] data);
    int            exp_id;
    logic [DW-1:0] e0, e1, er;
    logic [1:0]    em;
    bit            seen;
    id = -1; data = '0; seen = 1'b0;
    rsp_ready = (hold == 0);
    for (int c = 0; c < 8 && !seen; c++) begin
      @(negedge clk);
      if (req_ready != '0) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check("grant_seen", DW'(seen), DW'(1));
    if (!seen) return;
    exp_id = ref_winner(req_valid, mptr);
    check("grant_onehot", DW'(req_ready), DW'(NUM_REQ'(1) << exp_id));
    e0 = req_op0[exp_id*DW +: DW];
    e1 = req_op1[exp_id*DW +: DW];
    em = req_mode[exp_id*2 +: 2];
    er = alu_fn(e0, e1, em);
    mptr = (exp_id + 1) % NUM_REQ;
    @(posedge clk); #1;
    check("exec_op0", alu_op0, e0);
    check("exec_op1", alu_op1, e1);
    check("exec_mode", DW'(alu_mode), DW'(em));
    check("exec_rsp_valid", DW'(rsp_valid), DW'(0));
    check("exec_busy", DW'(busy), DW'(1));
    check("exec_req_ready", DW'(req_ready), DW'(0));
    @(posedge clk); #1;
    check("resp_valid", DW'(rsp_valid), DW'(1));
    check("resp_data", rsp_data, er);
    check("resp_id", DW'(rsp_id), DW'(exp_id));
    id = int'(rsp_id);
    data = rsp_data;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("stall_valid", DW'(rsp_valid), DW'(1));
      check("stall_data", rsp_data, er);
      check("stall_id", DW'(rsp_id), DW'(exp_id));
      check("stall_req_ready", DW'(req_ready), DW'(0));
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("idle_rsp_valid", DW'(rsp_valid), DW'(0));
    check("idle_busy", DW'(busy), DW'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int            id;
    logic [DW-1:0] d;

    rst = 1'b1; req_valid = '0; req_op0 = '0; req_op1 = '0; req_mode = '0; rsp_ready = 1'b1;
    #1;
    check("rst_req_ready", DW'(req_ready), DW'(0));
    check("rst_rsp_valid", DW'(rsp_valid), DW'(0));
    check("rst_busy", DW'(busy), DW'(0));
    check("rst_alu_op0", alu_op0, '0);
    check("rst_alu_mode", DW'(alu_mode), DW'(0));
    check("rst_rsp_data", rsp_data, '0);
    check("rst_rsp_id", DW'(rsp_id), DW'(0));
    @(posedge clk); #1 rst = 1'b0;
    mptr = 0;

    // Single ADD with per-lane wrap
    req_op0[0 +: DW] = {32{8'hF0}};
    req_op1[0 +: DW] = {32{8'h20}};
    req_mode[1:0] = 2'b00;
    req_valid = 4'b0001;
    serve(0, id, d);
    req_valid = '0;
    check("add_lanes", d, {32{8'h10}});
    check("add_id", DW'(id), DW'(0));

    // Logic modes on requester 1
    req_op0[DW +: DW] = {32{8'hAA}};
    req_op1[DW +: DW] = {32{8'h0F}};
    req_mode[3:2] = 2'b01; req_valid = 4'b0010;
    serve(0, id, d);
    check("and_data", d, {32{8'h0A}});
    req_mode[3:2] = 2'b10;
    serve(0, id, d);
    check("or_data", d, {32{8'hAF}});
    req_mode[3:2] = 2'b11;
    serve(0, id, d);
    check("xor_data", d, {32{8'hA5}});
    check("xor_id", DW'(id), DW'(1));
    req_valid = '0;

    // Fairness with every requester continuously valid
    do_reset();
    req_op0 = rand_vec(); req_op1 = rand_vec(); req_mode = 8'b11100100;
    req_valid = 4'b1111;
    for (int i = 0; i < 12; i++) begin
      serve(0, id, d);
      check("fair_id", DW'(id), DW'(i % 4));
    end

    // Backpressure: response held 10 cycles, then next grant
    req_valid = 4'b0001;
    serve(10, id, d);
    check("bp_id", DW'(id), DW'(0));
    serve(0, id, d);
    check("bp_next_id", DW'(id), DW'(0));
    req_valid = '0;

    // Pointer advance past the winner
    do_reset();
    req_valid = 4'b0100;
    serve(0, id, d);
    check("ptr_grant2", DW'(id), DW'(2));
    check("ptr_value", DW'(dut.rr_ptr_q), DW'(3));
    req_valid = 4'b1001;
    serve(0, id, d);
    check("ptr_grant3", DW'(id), DW'(3));
    req_valid = '0;

    // Reset while in EXEC discards the op
    do_reset();
    req_valid = 4'b1010;
    @(negedge clk);
    check("pre_rst_grant", DW'(req_ready), DW'(4'b0010));
    @(posedge clk); #1;
    check("in_exec_busy", DW'(busy), DW'(1));
    rst = 1'b1;
    #1;
    check("mid_rst_rsp_valid", DW'(rsp_valid), DW'(0));
    check("mid_rst_busy", DW'(busy), DW'(0));
    check("mid_rst_req_ready", DW'(req_ready), DW'(0));
    @(posedge clk); #1 rst = 1'b0;
    mptr = 0;
    check("post_rst_rsp_valid", DW'(rsp_valid), DW'(0));
    serve(0, id, d);
    check("post_rst_lowest", DW'(id), DW'(1));
    req_valid = '0;

    // Randomized traffic against the reference model
    for (int n = 0; n < 40; n++) begin
      req_op0  = rand_vec();
      req_op1  = rand_vec();
      req_mode = NUM_REQ*2'($urandom);
      req_valid = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
      serve(int'($urandom_range(0, 3)), id, d);
    end
    req_valid = '0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
